// File: rtl/cond_pkg.sv
// Shared types and bit indices for the conditional-execution unit.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE, CS, CC, MI, PL, VS, VC,
    HI, LS, GE, LT, GT, LE, AL,
    NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int WE_NZ = 1;
  localparam int WE_CV = 0;

  typedef struct packed {
    logic cond_ex;
    logic undef;
    logic pc_src;
    logic reg_write;
    logic mem_write;
  } ce_rsp_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-field evaluator against one NZCV set.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex,
  output logic       undef
);

  logic n, z, c, v;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    undef   = 1'b0;
    case (cond_e'(cond))
      EQ: cond_ex = z;
      NE: cond_ex = ~z;
      CS: cond_ex = c;
      CC: cond_ex = ~c;
      MI: cond_ex = n;
      PL: cond_ex = ~n;
      VS: cond_ex = v;
      VC: cond_ex = ~v;
      HI: cond_ex = c & ~z;
      LS: cond_ex = ~c | z;
      GE: cond_ex = (n == v);
      LT: cond_ex = (n != v);
      GT: cond_ex = ~z & (n == v);
      LE: cond_ex = z | (n != v);
      AL: cond_ex = 1'b1;
      default: undef = 1'b1;  // NV: never executes
    endcase
  end

endmodule

// File: rtl/cond_exec_unit.sv
// Multi-context NZCV banks, condition gating and flag commit, one-cycle registered.
// Optional squash counter enabled by defining CONDEXEC_SQUASH_CNT_EN.
module cond_exec_unit
  import cond_pkg::*;
#(
  parameter  int NUM_CTX = 4,
  parameter  int CNT_W   = 16,
  localparam int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CTX_W-1:0] in_ctx,
  input  logic [3:0]       in_cond,
  input  logic [1:0]       in_flag_we,
  input  logic [3:0]       in_alu_flags,
  input  logic             in_pc_src,
  input  logic             in_reg_write,
  input  logic             in_mem_write,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CTX_W-1:0] out_ctx,
  output logic             out_cond_ex,
  output logic             out_undef,
  output logic             out_pc_src,
  output logic             out_reg_write,
  output logic             out_mem_write,
  input  logic             flush,
  input  logic             rst_wr_en,
  input  logic [CTX_W-1:0] rst_wr_ctx,
  input  logic [3:0]       rst_wr_flags,
  input  logic [CTX_W-1:0] rd_ctx,
  output logic [3:0]       rd_flags,
  output logic [CNT_W-1:0] squash_cnt,
  input  logic             cnt_clr
);

  logic [3:0] flags_q [NUM_CTX];
  logic [3:0] flags_d [NUM_CTX];
  logic [3:0] cur_flags;
  logic       ev_ex, ev_undef;
  logic       accept, commit;
  ce_rsp_t    rsp_q;

  assign in_ready = ~flush & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign commit   = accept & ev_ex;

  // Out-of-range contexts match no bank, so reads fall through to zero.
  always_comb begin
    cur_flags = '0;
    rd_flags  = '0;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (in_ctx == CTX_W'(i)) cur_flags = flags_q[i];
      if (rd_ctx == CTX_W'(i)) rd_flags  = flags_q[i];
    end
  end

  cond_eval u_eval (
    .cond    (in_cond),
    .flags   (cur_flags),
    .cond_ex (ev_ex),
    .undef   (ev_undef)
  );

  // Restore is applied last so it overrides a same-context commit entirely.
  always_comb begin
    for (int i = 0; i < NUM_CTX; i++) begin
      flags_d[i] = flags_q[i];
      if (commit && in_ctx == CTX_W'(i)) begin
        if (in_flag_we[WE_NZ]) flags_d[i][FLAG_N:FLAG_Z] = in_alu_flags[FLAG_N:FLAG_Z];
        if (in_flag_we[WE_CV]) flags_d[i][FLAG_C:FLAG_V] = in_alu_flags[FLAG_C:FLAG_V];
      end
      if (rst_wr_en && rst_wr_ctx == CTX_W'(i)) flags_d[i] = rst_wr_flags;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CTX; i++) flags_q[i] <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_ctx   <= '0;
      rsp_q     <= '0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (accept)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (accept) begin
        out_ctx         <= in_ctx;
        rsp_q.cond_ex   <= ev_ex;
        rsp_q.undef     <= ev_undef;
        rsp_q.pc_src    <= in_pc_src    & ev_ex;
        rsp_q.reg_write <= in_reg_write & ev_ex;
        rsp_q.mem_write <= in_mem_write & ev_ex;
      end
    end
  end

  assign out_cond_ex   = rsp_q.cond_ex;
  assign out_undef     = rsp_q.undef;
  assign out_pc_src    = rsp_q.pc_src;
  assign out_reg_write = rsp_q.reg_write;
  assign out_mem_write = rsp_q.mem_write;

`ifdef CONDEXEC_SQUASH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              cnt_q <= '0;
    else if (cnt_clr)                        cnt_q <= '0;
    else if (accept && !ev_ex && !(&cnt_q))  cnt_q <= cnt_q + CNT_W'(1);
  end

  assign squash_cnt = cnt_q;
`else
  logic cnt_clr_unused;
  assign cnt_clr_unused = cnt_clr;
  assign squash_cnt     = '0;
`endif

endmodule

// File: doc/cond_exec_unit.md
Name: cond_exec_unit

Overview:
- Registered, multi-context successor of the single-cycle condition checker in the control unit.
- Holds one NZCV flag bank per hardware context and evaluates the 4-bit ARM condition field against the issuing context's bank.
- Gates the instruction's side-effect controls (PCSrc, RegWrite, MemWrite) and commits ALU flags per S-bit write enables.
- Sits between decode and writeback control; valid/ready handshake on both sides, one-cycle latency.

Parameters:
NUM_CTX, 4, number of flag banks/contexts (>=1); CTX_W = max(1, $clog2(NUM_CTX)) is a derived localparam
CNT_W, 16, width of the saturating squash counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  unit can accept
in_ctx  in  CTX_W  issuing context
in_cond  in  4  condition field Instr[31:28]
in_flag_we  in  2  [1]=write N,Z; [0]=write C,V
in_alu_flags  in  4  {N,Z,C,V} from ALU
in_pc_src  in  1  raw PCSrc
in_reg_write  in  1  raw RegWrite
in_mem_write  in  1  raw MemWrite
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_ctx  out  CTX_W  context of result
out_cond_ex  out  1  condition passed
out_undef  out  1  cond == 4'b1111
out_pc_src  out  1  gated PCSrc
out_reg_write  out  1  gated RegWrite
out_mem_write  out  1  gated MemWrite
flush  in  1  synchronous pipeline kill
rst_wr_en  in  1  context-restore flag write
rst_wr_ctx  in  CTX_W  restore target
rst_wr_flags  in  4  restore value
rd_ctx  in  CTX_W  save/read port select
rd_flags  out  4  combinational flags[rd_ctx]
squash_cnt  out  CNT_W  count of squashed instructions
cnt_clr  in  1  synchronous counter clear

Behaviour:
- Reset (reset=0, asynchronous): all flag banks = 4'b0000; out_valid, out_* outputs, squash_cnt = 0.
- Handshake: in_ready = ~flush & (~out_valid | out_ready). Accept = in_valid & in_ready. Output register loads on accept; out_valid holds, with outputs stable, while out_valid & ~out_ready.
- Latency: 1 cycle from accept to out_valid.
- Evaluation on accept uses the flag bank of in_ctx before any update this cycle:
  - Codes 0000..1110 follow ARM semantics: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL, with GE = (N==V).
  - Code 1111: cond_ex=0, out_undef=1. Never X.
- Gating: out_pc_src = in_pc_src & cond_ex; the same gating applies to reg_write and mem_write.
- Flag commit, on accept & cond_ex:
  - flags[in_ctx].NZ <= in_alu_flags[3:2] if in_flag_we[1].
  - flags[in_ctx].CV <= in_alu_flags[1:0] if in_flag_we[0].
  - A squashed instruction never writes flags.
- Back-to-back instructions on the same context: the second sees the first's committed flags; no forwarding is needed.
- Restore port: rst_wr_en writes all 4 flags of rst_wr_ctx. If it targets the same context as a pipeline commit in the same cycle, the restore wins in full. Different contexts: both writes occur.
- rd_flags reflects the registered bank, i.e. it excludes same-cycle writes.
- flush=1:
  - next cycle out_valid=0;
  - no accept, no flag commit from the pipeline;
  - a restore write still occurs;
  - flush overrides a pending stall.
- squash_cnt:
  - +1 on each accept with cond_ex=0 (undef included);
  - saturates at all-ones;
  - cnt_clr sets it to 0 and has priority over an increment in the same cycle.
- Out-of-range ctx values (NUM_CTX not a power of 2): reads return 0 and writes are ignored.

Optional Feature:
- Macro: CONDEXEC_SQUASH_CNT_EN.
- Defined: squash counter built as described.
- Undefined: no counter flops; squash_cnt tied to 0; cnt_clr ignored. All other behaviour is identical.

Decomposition:
- Package cond_pkg:
  - cond_e enum with 4-bit encodings EQ..AL, NV=4'b1111;
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - flag_we bit indices WE_NZ=1, WE_CV=0.
- One sub-module, cond_eval: purely combinational, inputs (cond, flags), outputs (cond_ex, undef). It is instantiated once.
- Flag banks, handshake and counter live in cond_exec_unit.

Test Plan:
- Reset, then ctx0 issues cond=EQ(0000) with flags 0000 → out_cond_ex=0, out_reg_write=0, squash_cnt=1 one cycle after accept.
- ctx1 issues AL with we=2'b11, alu=0100; next cycle ctx1 issues EQ with reg_write=1 → second out_cond_ex=1, out_reg_write=1; rd_ctx=1 reads 0100; ctx0 still reads 0000.
- Squashed write: ctx2 flags=1000 (restore), issue GE with we=11, alu=0000 → cond_ex=0 (N≠V), flags[2] stay 1000.
- Collision: same cycle, restore ctx3 ← 0011 and an AL commit of 1100 to ctx3 → rd_flags(ctx3)=0011.
- Stall then flush:
  - hold out_ready=0 for 3 cycles → outputs stable, in_ready=0;
  - assert flush → out_valid=0 next cycle, in_ready=0 during flush.
- Counter: cond=1111 → out_undef=1, all gated outputs 0; force squash_cnt to 0xFFFF via repeated squashes → stays 0xFFFF; cnt_clr with a simultaneous squash → 0.
